play_cmd_arbiter: RTL
=====================

Name: play_cmd_arbiter

Overview:
Arbitrates playback commands from three sources: the decoded bluetooth UART byte stream, the debounced on-board buttons, and the decoder's end-of-song event. It sequences them one at a time into the MP3 player control state: song index, pause, and volume attenuation level. A hold-off timer rate-limits track and volume changes. It sits between the UART/button front ends and the player/display datapath, and replaces the ad-hoc per-source command handling.

Parameters:
SONG_NUM, 4, number of songs; index wraps in 0..SONG_NUM-1 (SONG_NUM <= 8).
VOL_MAX, 8, maximum attenuation level (0 = loudest).
HOLDOFF, 50000000, clock cycles of lockout after NEXT/PRE/VOL commands (50 MHz clock, 1 s).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
bt_valid  in  1  one-cycle strobe; bt_cmd is valid.
bt_cmd  in  3  bluetooth command code.
btn_valid  in  1  one-cycle strobe; btn_cmd is valid.
btn_cmd  in  3  button command code.
i_finish_song  in  1  level/pulse from decoder; song ended.
o_song_select  out  3  current song index.
o_vol_level  out  4  attenuation level 0..VOL_MAX.
o_pause  out  1  1 = paused.
o_next, o_pre, o_vol_plus, o_vol_dec  out  1 each  one-cycle strobes, user-initiated commands only.
o_song_change  out  1  one-cycle strobe on any song index change, including auto-advance.
o_busy  out  1  high whenever FSM is not IDLE.
o_drop_cnt  out  8  saturating count of dropped commands.

Behaviour:
- Reset (async, rst=1): o_song_select=0, o_vol_level=0, o_pause=1, all strobes 0, o_busy=0, o_drop_cnt=0, all pending slots empty, FSM=IDLE, hold-off counter=0. Reset asserted mid-HOLD aborts the lockout immediately.
- Command codes: 0 none, 1 PAUSE, 2 NEXT, 3 PRE, 4 VOL_PLUS, 5 VOL_DEC, 6 REPEAT (optional feature), 7 reserved. Codes 0 and 7 are ignored and do not count as drops. Code 6 is also ignored when the feature is compiled out.
- Pending slots: one slot each for bt, btn, and fin.
  - A valid strobe with a legal code loads its slot if the slot is empty.
  - If the slot is full, the new command is dropped and o_drop_cnt increments, saturating at 255.
  - fin slot is set on the rising edge of i_finish_song. A repeat edge while fin is set is absorbed and not counted.
  - If a slot is consumed and reloaded on the same edge, the new command is captured.
- FSM IDLE: if any slot is full, select by fixed priority fin > btn > bt, latch the command, clear that slot, go to EXEC. Otherwise stay.
- FSM EXEC (1 cycle): apply the command; strobes are high for exactly the cycle after EXEC.
  - PAUSE: o_pause toggles; return to IDLE.
  - NEXT: index = (idx==SONG_NUM-1) ? 0 : idx+1; o_next and o_song_change pulse; go to HOLD.
  - PRE: index = (idx==0) ? SONG_NUM-1 : idx-1; o_pre and o_song_change pulse; go to HOLD.
  - VOL_PLUS: level = (level==0) ? 0 : level-1; o_vol_plus pulses; go to HOLD. Strobe pulses even when saturated.
  - VOL_DEC: level = (level==VOL_MAX) ? VOL_MAX : level+1; o_vol_dec pulses; go to HOLD.
  - fin (auto-advance): same index update as NEXT with o_song_change only (o_next stays 0); no HOLD, return to IDLE. o_pause is unchanged.
- FSM HOLD: counter counts 1..HOLDOFF, then clears and returns to IDLE. Slots keep capturing during HOLD.
- Latency from IDLE with empty slots: valid sampled at edge 0 → EXEC entered at edge 1 → outputs and strobe update at edge 2. The strobe is high from edge 2 to edge 3.
- Simultaneous bt and btn commands in the same cycle: both are captured; btn executes first.

Optional Feature:
REPEAT_ONE_EN.
- Defined: adds register repeat_one (reset 0). Code 6 toggles it in EXEC and returns to IDLE. While repeat_one=1, a fin command leaves the index unchanged but still pulses o_song_change (the song restarts). NEXT/PRE are unaffected.
- Undefined: code 6 is ignored, and fin always advances.

Test Plan:
- Reset, then bt_cmd=1 → o_pause goes 1→0 two edges after the strobe; o_busy high for 1 cycle; no other strobe.
- idx=3, SONG_NUM=4, btn NEXT → o_song_select=0, o_next and o_song_change one cycle each; o_busy high HOLDOFF+1 cycles (use HOLDOFF=10 in sim).
- PRE at idx=0 → idx=3. VOL_PLUS at level 0 → level stays 0, o_vol_plus still pulses. VOL_DEC ×9 from 0 (HOLDOFF=10) → level saturates at 8.
- During HOLD, send bt NEXT twice, then btn PRE in the same cycle as i_finish_song rising → o_drop_cnt=1; execution order fin, btn PRE, bt NEXT; final idx matches.
- Assert rst mid-HOLD with pending slots → all outputs at reset values at once; no strobe after release until a new command arrives.
- REPEAT_ONE_EN defined: bt code 6, then i_finish_song pulse at idx=2 → idx stays 2, o_song_change pulses, o_next stays 0. Macro undefined: idx becomes 3.

Source files
------------

// File: rtl/play_cmd_arbiter.sv
// Playback command arbiter: bt/button/end-of-song slots sequenced through IDLE/EXEC/HOLD
// into song index, pause and volume state. Optional REPEAT_ONE_EN adds the repeat-one toggle.
module play_cmd_arbiter #(
   parameter int SONG_NUM = 4,
   parameter int VOL_MAX  = 8,
   parameter int HOLDOFF  = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bt_valid,
   input  logic [2:0] bt_cmd,
   input  logic       btn_valid,
   input  logic [2:0] btn_cmd,
   input  logic       i_finish_song,
   output logic [2:0] o_song_select,
   output logic [3:0] o_vol_level,
   output logic       o_pause,
   output logic       o_next,
   output logic       o_pre,
   output logic       o_vol_plus,
   output logic       o_vol_dec,
   output logic       o_song_change,
   output logic       o_busy,
   output logic [7:0] o_drop_cnt
);

   localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
   localparam logic [2:0] LAST_SONG = 3'(SONG_NUM - 1);
   localparam logic [3:0] VOL_TOP   = 4'(VOL_MAX);

   typedef enum logic [2:0] {
      C_NONE, C_PAUSE, C_NEXT, C_PRE, C_VPLUS, C_VDEC, C_REPEAT, C_RSVD
   } cmd_e;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_e;

   function automatic logic cmd_legal(input logic [2:0] c);
`ifdef REPEAT_ONE_EN
      cmd_legal = (c != 3'd0) && (c != 3'd7);
`else
      cmd_legal = (c >= 3'd1) && (c <= 3'd5);
`endif
   endfunction

   state_e           state, state_nx;
   logic             bt_full, btn_full, fin_full, fin_d;
   logic [2:0]       bt_slot, btn_slot;
   cmd_e             exec_cmd;
   logic             exec_fin;
   logic             exec_holds;
   logic             pick_fin, pick_btn, pick_bt;
   logic             fin_rise, bt_take, btn_take, bt_drop, btn_drop;
   logic [8:0]       drop_sum;
   logic [CNT_W-1:0] hold_cnt;
   logic [2:0]       song_inc, song_dec;
`ifdef REPEAT_ONE_EN
   logic             repeat_one;
`endif

   // Fixed priority fin > btn > bt, only granted from IDLE
   always_comb begin
      pick_fin = 1'b0;
      pick_btn = 1'b0;
      pick_bt  = 1'b0;
      if (state == S_IDLE) begin
         if (fin_full)      pick_fin = 1'b1;
         else if (btn_full) pick_btn = 1'b1;
         else if (bt_full)  pick_bt  = 1'b1;
      end
   end

   assign fin_rise  = i_finish_song & ~fin_d;
   assign bt_take   = bt_valid & cmd_legal(bt_cmd);
   assign btn_take  = btn_valid & cmd_legal(btn_cmd);
   // A slot emptied by this cycle's grant counts as free for the incoming command
   assign bt_drop   = bt_take & bt_full & ~pick_bt;
   assign btn_drop  = btn_take & btn_full & ~pick_btn;
   assign drop_sum  = {1'b0, o_drop_cnt} + {8'd0, bt_drop} + {8'd0, btn_drop};

   assign song_inc  = (o_song_select == LAST_SONG) ? 3'd0 : o_song_select + 3'd1;
   assign song_dec  = (o_song_select == 3'd0) ? LAST_SONG : o_song_select - 3'd1;
   assign exec_holds = ~exec_fin & (exec_cmd inside {C_NEXT, C_PRE, C_VPLUS, C_VDEC});
   assign o_busy    = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bt_full    <= 1'b0;
         btn_full   <= 1'b0;
         fin_full   <= 1'b0;
         fin_d      <= 1'b0;
         bt_slot    <= 3'd0;
         btn_slot   <= 3'd0;
         o_drop_cnt <= 8'd0;
      end else begin
         fin_d <= i_finish_song;
         if (pick_fin) fin_full <= 1'b0;
         if (fin_rise) fin_full <= 1'b1;
         if (pick_bt) bt_full <= 1'b0;
         if (bt_take && !bt_drop) begin
            bt_full <= 1'b1;
            bt_slot <= bt_cmd;
         end
         if (pick_btn) btn_full <= 1'b0;
         if (btn_take && !btn_drop) begin
            btn_full <= 1'b1;
            btn_slot <= btn_cmd;
         end
         o_drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exec_cmd <= C_NONE;
         exec_fin <= 1'b0;
      end else if (pick_fin | pick_btn | pick_bt) begin
         exec_fin <= pick_fin;
         exec_cmd <= pick_fin ? C_NONE : cmd_e'(pick_btn ? btn_slot : bt_slot);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (fin_full | btn_full | bt_full) state_nx = S_EXEC;
         S_EXEC:  state_nx = exec_holds ? S_HOLD : S_IDLE;
         S_HOLD:  if (hold_cnt == HOLD_LAST) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (state == S_HOLD) begin
         hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + CNT_W'(1);
      end else begin
         hold_cnt <= '0;
      end
   end

   // Player state; strobes are registered so they land in the cycle after EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_song_select <= 3'd0;
         o_vol_level   <= 4'd0;
         o_pause       <= 1'b1;
         o_next        <= 1'b0;
         o_pre         <= 1'b0;
         o_vol_plus    <= 1'b0;
         o_vol_dec     <= 1'b0;
         o_song_change <= 1'b0;
`ifdef REPEAT_ONE_EN
         repeat_one    <= 1'b0;
`endif
      end else begin
         o_next        <= 1'b0;
         o_pre         <= 1'b0;
         o_vol_plus    <= 1'b0;
         o_vol_dec     <= 1'b0;
         o_song_change <= 1'b0;
         if (state == S_EXEC) begin
            if (exec_fin) begin
               o_song_change <= 1'b1;
`ifdef REPEAT_ONE_EN
               if (!repeat_one) o_song_select <= song_inc;
`else
               o_song_select <= song_inc;
`endif
            end else begin
               case (exec_cmd)
                  C_PAUSE: o_pause <= ~o_pause;
                  C_NEXT: begin
                     o_song_select <= song_inc;
                     o_next        <= 1'b1;
                     o_song_change <= 1'b1;
                  end
                  C_PRE: begin
                     o_song_select <= song_dec;
                     o_pre         <= 1'b1;
                     o_song_change <= 1'b1;
                  end
                  C_VPLUS: begin
                     if (o_vol_level != 4'd0) o_vol_level <= o_vol_level - 4'd1;
                     o_vol_plus <= 1'b1;
                  end
                  C_VDEC: begin
                     if (o_vol_level != VOL_TOP) o_vol_level <= o_vol_level + 4'd1;
                     o_vol_dec <= 1'b1;
                  end
`ifdef REPEAT_ONE_EN
                  C_REPEAT: repeat_one <= ~repeat_one;
`endif
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
